// File: rtl/fp_vec_sequencer_pkg.sv
// fp_vec_sequencer_pkg: sequencer state type and vector-word
// field positions shared by the sequencer, its bus and its bench.
package fp_vec_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } fp_seq_state_t;

  function automatic int vec_wid(int fpwid, int nops);
    return 4 + (nops + 1) * fpwid;
  endfunction

  function automatic int op_lsb(int fpwid, int idx);
    return idx * fpwid;
  endfunction

  function automatic int exp_lsb(int fpwid, int nops);
    return nops * fpwid;
  endfunction

  function automatic int rm_lsb(int fpwid, int nops);
    return (nops + 1) * fpwid;
  endfunction

endpackage

// File: rtl/fp_vec_sequencer_if.sv
// fp_vec_sequencer_if: control, vector ROM, unit-under-test and
// capture signals of the FP vector sequencer.
interface fp_vec_sequencer_if #(
  parameter int FPWID = 64,
  parameter int NOPS  = 3,
  parameter int AWID  = 15
);
  import fp_vec_sequencer_pkg::*;

  localparam int VWID = vec_wid(FPWID, NOPS);

  logic                      start;
  logic                      stop;
  logic [AWID-1:0]           nvec;
  logic                      vec_rd;
  logic [AWID-1:0]           vec_adr;
  logic [VWID-1:0]           vec_dat;
  logic                      valid_o;
  logic [NOPS*FPWID-1:0]     op_o;
  logic [2:0]                rm_o;
  logic [FPWID-1:0]          res_i;
  logic                      cap_we;
  logic [AWID-1:0]           cap_adr;
  logic [(NOPS+1)*FPWID-1:0] cap_dat;
  logic                      busy;
  logic                      done;
  logic [31:0]               err_cnt;
  logic [AWID-1:0]           first_err_adr;
  logic                      err_seen;

  modport master (
    input  start, stop, nvec, vec_dat, res_i,
    output vec_rd, vec_adr, valid_o, op_o, rm_o,
    output cap_we, cap_adr, cap_dat,
    output busy, done, err_cnt, first_err_adr, err_seen
  );

  modport slave (
    output start, stop, nvec, vec_dat, res_i,
    input  vec_rd, vec_adr, valid_o, op_o, rm_o,
    input  cap_we, cap_adr, cap_dat,
    input  busy, done, err_cnt, first_err_adr, err_seen
  );

endinterface

// File: rtl/fp_delay_line.sv
// fp_delay_line: fixed-depth shift line; the MSB of every stage is
// that stage's valid bit and occ reports any valid stage in flight.
module fp_delay_line #(
  parameter int WID   = 8,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] d,
  output logic [WID-1:0] q,
  output logic           occ
);

  logic [WID-1:0] stg [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  always_comb begin
    occ = 1'b0;
    for (int i = 0; i < DEPTH; i++) occ = occ | stg[i][WID-1];
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/fp_vec_sequencer.sv
// fp_vec_sequencer: streams ROM vectors into a fixed-latency FP unit,
// then captures and checks each result against its expected value.
module fp_vec_sequencer
  import fp_vec_sequencer_pkg::*;
#(
  parameter int FPWID = 64,
  parameter int NOPS  = 3,
  parameter int LAT   = 27,
  parameter int GAP   = 0,
  parameter int AWID  = 15
) (
  input logic                clk,
  input logic                rst,
  fp_vec_sequencer_if.master bus
);

  localparam int OW = NOPS * FPWID;
  localparam int CW = (NOPS + 1) * FPWID;
  localparam int DW = 1 + AWID + CW;
  localparam int OL = op_lsb(FPWID, 0);
  localparam int EL = exp_lsb(FPWID, NOPS);
  localparam int RL = rm_lsb(FPWID, NOPS);
  localparam int GW = $clog2(GAP + 2);

  fp_seq_state_t state, nxt;

  logic [AWID-1:0]  nv_q, rd_cnt, rd_adr_q;
  logic [GW-1:0]    gap_cnt;
  logic             rd, last, accept, empty, rd_q;
  logic             iss_vld;
  logic [AWID-1:0]  iss_adr;
  logic [FPWID-1:0] iss_exp;
  logic [OW-1:0]    iss_ops;
  logic [2:0]       iss_rm;
  logic [DW-1:0]    dl_q;
  logic             dl_occ, dl_vld;
  logic [AWID-1:0]  dl_adr;
  logic [FPWID-1:0] dl_exp;
  logic [OW-1:0]    dl_ops;
  logic             cap_we;
  logic [AWID-1:0]  cap_adr, first_err;
  logic [CW-1:0]    cap_dat;
  logic [31:0]      err_cnt;
  logic             err_seen;
  logic             unused_rm3;

  assign rd     = (state == S_RUN) && (gap_cnt == '0);
  assign last   = (rd_cnt + AWID'(1)) == nv_q;
  assign accept = (state == S_IDLE) && bus.start;
  assign empty  = !rd_q && !iss_vld && !dl_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) nxt = (bus.nvec == '0) ? S_FIN : S_RUN;
      S_RUN:   if (bus.stop || (rd && last)) nxt = S_DRAIN;
      S_DRAIN: if (empty) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nv_q    <= '0;
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else if (accept) begin
      nv_q    <= bus.nvec;
      rd_cnt  <= '0;
      gap_cnt <= '0;
    end else if (rd) begin
      rd_cnt  <= rd_cnt + AWID'(1);
      gap_cnt <= GW'(GAP);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // ROM data lands the cycle after the read; register it as the issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= 1'b0;
      rd_adr_q <= '0;
      iss_vld  <= 1'b0;
      iss_adr  <= '0;
      iss_exp  <= '0;
      iss_ops  <= '0;
      iss_rm   <= '0;
    end else begin
      rd_q    <= rd;
      iss_vld <= rd_q;
      if (rd) rd_adr_q <= rd_cnt;
      if (rd_q) begin
        iss_adr <= rd_adr_q;
        iss_exp <= bus.vec_dat[EL +: FPWID];
        iss_ops <= bus.vec_dat[OL +: OW];
        iss_rm  <= bus.vec_dat[RL +: 3];
      end
    end
  end

  fp_delay_line #(
    .WID   (DW),
    .DEPTH (LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   ({iss_vld, iss_adr, iss_exp, iss_ops}),
    .q   (dl_q),
    .occ (dl_occ)
  );

  assign dl_vld = dl_q[DW-1];
  assign dl_adr = dl_q[CW +: AWID];
  assign dl_exp = dl_q[OW +: FPWID];
  assign dl_ops = dl_q[OW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_adr   <= '0;
      cap_dat   <= '0;
      err_cnt   <= '0;
      err_seen  <= 1'b0;
      first_err <= '0;
    end else begin
      cap_we <= dl_vld;
      if (dl_vld) begin
        cap_adr <= dl_adr;
        cap_dat <= {bus.res_i, dl_ops};
      end
      if (accept) begin
        err_cnt   <= '0;
        err_seen  <= 1'b0;
        first_err <= '0;
      end else if (dl_vld && (bus.res_i != dl_exp)) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        if (!err_seen) begin
          err_seen  <= 1'b1;
          first_err <= dl_adr;
        end
      end
    end
  end

  assign unused_rm3        = bus.vec_dat[RL+3];
  assign bus.vec_rd        = rd;
  assign bus.vec_adr       = rd_cnt;
  assign bus.valid_o       = iss_vld;
  assign bus.op_o          = iss_ops;
  assign bus.rm_o          = iss_rm;
  assign bus.cap_we        = cap_we;
  assign bus.cap_adr       = cap_adr;
  assign bus.cap_dat       = cap_dat;
  assign bus.busy          = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done          = (state == S_FIN);
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_adr = first_err;
  assign bus.err_seen      = err_seen;

endmodule

// File: tb/tb_fp_vec_sequencer.sv
// tb_fp_vec_sequencer: random vector runs checked through issue and
// capture scoreboards fed by a queue-level reference of each run.
`timescale 1ns/1ps
module tb_fp_vec_sequencer;
  localparam int FPWID = 64;
  localparam int NOPS  = 3;
  localparam int LAT   = 3;
  localparam int AWID  = 8;
  localparam int VWID  = 4 + (NOPS + 1) * FPWID;
  localparam int OW    = NOPS * FPWID;
  localparam int CW    = (NOPS + 1) * FPWID;

  typedef struct {
    logic [AWID-1:0] adr;
    logic [CW-1:0]   dat;
    int              cyc;
  } cap_t;

  typedef struct {
    logic [OW-1:0] ops;
    logic [2:0]    rm;
    int            cyc;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int gcap = 0;
  bit iss_chk = 1'b1;

  logic [VWID-1:0] rom [256];
  cap_t sbq[$];
  iss_t isq[$];
  int   gvq[$];

  fp_vec_sequencer_if #(.FPWID(FPWID), .NOPS(NOPS), .AWID(AWID)) b0 ();
  fp_vec_sequencer_if #(.FPWID(FPWID), .NOPS(NOPS), .AWID(AWID)) b2 ();

  fp_vec_sequencer #(
    .FPWID(FPWID), .NOPS(NOPS), .LAT(LAT), .GAP(0), .AWID(AWID)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.master)
  );

  fp_vec_sequencer #(
    .FPWID(FPWID), .NOPS(NOPS), .LAT(LAT), .GAP(2), .AWID(AWID)
  ) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector ROMs and identity units: result = op0 LAT cycles later
  logic [FPWID-1:0] p0 [LAT];
  logic [FPWID-1:0] p2 [LAT];
  always @(posedge clk) begin
    if (b0.vec_rd) b0.vec_dat <= rom[b0.vec_adr];
    if (b2.vec_rd) b2.vec_dat <= rom[b2.vec_adr];
    p0[0] <= b0.op_o[FPWID-1:0];
    p2[0] <= b2.op_o[FPWID-1:0];
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p2[i] <= p2[i-1];
    end
  end
  assign b0.res_i = p0[LAT-1];
  assign b2.res_i = p2[LAT-1];

  task automatic check(input string nm, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    cap_t e;
    iss_t s;
    int g;
    if (!rst && b0.cap_we) begin
      if (sbq.size() == 0) check("cap_unexpected", b0.cap_we, 0);
      else begin
        e = sbq.pop_front();
        check("cap_adr", b0.cap_adr, e.adr);
        check("cap_dat", b0.cap_dat, e.dat);
        check("cap_cyc", cyc, e.cyc);
      end
    end
    if (!rst && b0.valid_o && iss_chk) begin
      if (isq.size() == 0) check("iss_unexpected", b0.valid_o, 0);
      else begin
        s = isq.pop_front();
        check("op_o", b0.op_o, s.ops);
        check("rm_o", b0.rm_o, s.rm);
        check("iss_cyc", cyc, s.cyc);
      end
    end
    if (!rst && b2.valid_o) begin
      if (gvq.size() == 0) check("gap_unexpected", b2.valid_o, 0);
      else begin
        g = gvq.pop_front();
        check("gap_valid_cyc", cyc, g);
      end
    end
    if (!rst && b2.cap_we) gcap++;
  end

  task automatic chk_zero(input string nm);
    check({nm, "_vec_rd"}, b0.vec_rd, 0);
    check({nm, "_vec_adr"}, b0.vec_adr, 0);
    check({nm, "_valid_o"}, b0.valid_o, 0);
    check({nm, "_op_o"}, b0.op_o, 0);
    check({nm, "_rm_o"}, b0.rm_o, 0);
    check({nm, "_cap_we"}, b0.cap_we, 0);
    check({nm, "_cap_adr"}, b0.cap_adr, 0);
    check({nm, "_cap_dat"}, b0.cap_dat, 0);
    check({nm, "_busy"}, b0.busy, 0);
    check({nm, "_done"}, b0.done, 0);
    check({nm, "_err_cnt"}, b0.err_cnt, 0);
    check({nm, "_first_err"}, b0.first_err_adr, 0);
    check({nm, "_err_seen"}, b0.err_seen, 0);
  endtask

  function automatic logic [VWID-1:0] mk_vec(input logic [FPWID-1:0] a,
    input logic [FPWID-1:0] b, input logic [FPWID-1:0] c,
    input logic [FPWID-1:0] ex, input logic [3:0] rm);
    return {rm, ex, c, b, a};
  endfunction

  task automatic do_run(input int n, input int stop_at, input int bad_pct,
                        input int force_bad, input bit mid_start);
    int nis, nerr, ferr, t0, dc, bc, rc;
    logic [FPWID-1:0] op [NOPS];
    logic [FPWID-1:0] ex;
    logic [3:0] rm;
    cap_t c;
    iss_t s;
    nis = (stop_at >= 0 && stop_at + 1 < n) ? stop_at + 1 : n;
    nerr = 0;
    ferr = 0;
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NOPS; k++) op[k] = {$urandom, $urandom};
      ex = op[0];
      if (i == force_bad || $urandom_range(99) < bad_pct)
        ex = op[0] ^ (64'h1 << $urandom_range(63));
      rm = 4'($urandom);
      rom[i] = mk_vec(op[0], op[1], op[2], ex, rm);
      if (i < nis) begin
        c.adr = AWID'(i);
        c.dat = {op[0], op[2], op[1], op[0]};
        c.cyc = t0 + 4 + LAT + i;
        sbq.push_back(c);
        s.ops = {op[2], op[1], op[0]};
        s.rm  = rm[2:0];
        s.cyc = t0 + 3 + i;
        isq.push_back(s);
        if (ex != op[0]) begin
          if (nerr == 0) ferr = i;
          nerr++;
        end
      end
    end
    b0.start = 1'b1;
    b0.nvec  = AWID'(n);
    dc = -1;
    bc = 0;
    rc = 0;
    for (int cc = 1; cc <= 200 && dc < 0; cc++) begin
      @(negedge clk);
      b0.start = mid_start && (cc == 6);
      b0.stop  = 1'b0;
      if (b0.busy) bc++;
      if (b0.vec_rd) begin
        if (rc == stop_at) b0.stop = 1'b1;
        rc++;
      end
      if (b0.done) dc = cc;
    end
    b0.start = 1'b0;
    b0.stop  = 1'b0;
    check("done_cyc", dc, (n == 0) ? 1 : nis + 4 + LAT);
    check("busy_cycles", bc, (n == 0) ? 0 : nis + 3 + LAT);
    check("rd_count", rc, nis);
    check("err_cnt", b0.err_cnt, nerr);
    check("err_seen", b0.err_seen, nerr != 0);
    check("first_err_adr", b0.first_err_adr, ferr);
    check("caps_missing", sbq.size(), 0);
    check("issues_missing", isq.size(), 0);
    @(negedge clk);
    check("done_pulse", b0.done, 0);
    check("busy_after", b0.busy, 0);
  endtask

  task automatic gap_run();
    int t0, dc;
    for (int i = 0; i < 3; i++)
      rom[i] = mk_vec({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom}, 4'h0);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 3; i++) gvq.push_back(t0 + 3 + 3 * i);
    gcap = 0;
    b2.start = 1'b1;
    b2.nvec  = AWID'(3);
    dc = -1;
    for (int cc = 1; cc <= 100 && dc < 0; cc++) begin
      @(negedge clk);
      b2.start = 1'b0;
      if (b2.done) dc = cc;
    end
    check("gap_done_cyc", dc, 9 + LAT + 2);
    check("gap_caps", gcap, 3);
    check("gap_valid_missing", gvq.size(), 0);
  endtask

  task automatic reset_drain();
    int nd;
    logic [FPWID-1:0] a;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      rom[i] = mk_vec(a, a, a, a, 4'h5);
    end
    iss_chk = 1'b0;
    @(negedge clk);
    b0.start = 1'b1;
    b0.nvec  = AWID'(4);
    for (int cc = 1; cc <= 5; cc++) begin
      @(negedge clk);
      b0.start = 1'b0;
    end
    check("pre_rst_busy", b0.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    for (int cc = 0; cc < 20; cc++) begin
      @(negedge clk);
      if (b0.done) nd++;
    end
    check("rst_no_done", nd, 0);
    isq.delete();
    iss_chk = 1'b1;
  endtask

  initial begin
    b0.start = 1'b0;
    b0.stop  = 1'b0;
    b0.nvec  = '0;
    b2.start = 1'b0;
    b2.stop  = 1'b0;
    b2.nvec  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    do_run(4, -1, 0, -1, 1'b0);
    do_run(4, -1, 0, 2, 1'b0);
    reset_drain();
    do_run(4, -1, 0, -1, 1'b0);
    do_run(0, -1, 0, -1, 1'b0);
    do_run(10, 1, 0, -1, 1'b1);
    gap_run();
    for (int r = 0; r < 6; r++)
      do_run(int'($urandom_range(20, 1)), -1, 30, -1, 1'b0);
    do_run(12, 5, 30, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
